// File: rtl/shift_pkg.sv
// Shared definitions for the parallel/serial shift block family.
// Holds the unloader state encoding and the counter-width helper.
package shift_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } unload_state_t;

  // Bits needed for a counter that must hold the value len.
  function automatic int count_bits(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/shift_unloader_if.sv
// Load (vector) and unload (word stream) handshakes of shift_unloader.
// master: environment side (producer + consumer); slave: the unloader.
interface shift_unloader_if #(
  parameter int DATA_BITS = 8,
  parameter int LENGTH    = 4
);

  logic                          load_valid;
  logic                          load_ready;
  logic [DATA_BITS*LENGTH-1:0]   load_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_BITS-1:0]          out_data;
  logic                          out_last;

  modport master (
    output load_valid, load_data, out_ready,
    input  load_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  load_valid, load_data, out_ready,
    output load_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/shift_unloader.sv
// shift_unloader: parallel-in / serial-out word unloader.
// Captures one LENGTH-word vector per load handshake and streams it out
// word 0 first on a valid/ready interface, flagging the final word.
// Optional macro SHIFT_UNLOADER_BACKTOBACK_EN: accept the next vector in the
// same cycle as the last beat, removing the idle bubble between vectors.
module shift_unloader
  import shift_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int LENGTH    = 4
) (
  input  logic              clk,
  input  logic              reset,   // synchronous, active-low
  shift_unloader_if.slave   bus
);

  localparam int              CW       = count_bits(LENGTH);
  localparam int              VEC_BITS = DATA_BITS * LENGTH;
  localparam logic [CW-1:0]   LAST_IDX = CW'(LENGTH - 1);

  generate
    if (LENGTH < 1 || DATA_BITS < 1) begin : g_bad_param
      $error("shift_unloader: LENGTH and DATA_BITS must both be >= 1");
    end
  endgenerate

  unload_state_t       r_state;
  unload_state_t       w_state_next;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_next;
  logic [VEC_BITS-1:0] r_vec;
  logic [VEC_BITS-1:0] w_vec_next;
  logic                w_last;
  logic                w_load_ready;
  logic                w_load_fire;
  logic                w_beat_fire;

  // Handshake outputs and next-state decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_next = r_state;
    w_count_next = r_count;
    w_vec_next   = r_vec;
    w_load_ready = 1'b0;

    w_last      = (r_state == SHIFT) && (r_count == LAST_IDX);
    w_beat_fire = (r_state == SHIFT) && bus.out_ready;

    // Load acceptance depends only on state, count and out_ready, never on
    // load_valid, so no combinational loop can form through the producer.
    if (reset) begin
`ifdef SHIFT_UNLOADER_BACKTOBACK_EN
      w_load_ready = (r_state == IDLE) || (w_last && bus.out_ready);
`else
      w_load_ready = (r_state == IDLE);
`endif
    end
    w_load_fire = bus.load_valid && w_load_ready;

    if (w_beat_fire) begin
      // Word 0 leaves; the rest move down and zeros enter at the top.
      w_vec_next = r_vec >> DATA_BITS;
      if (w_last) begin
        w_count_next = '0;
        w_state_next = IDLE;
      end else begin
        w_count_next = r_count + 1'b1;
      end
    end

    // A load accepted alongside the last beat overrides the return to IDLE.
    if (w_load_fire) begin
      w_vec_next   = bus.load_data;
      w_count_next = '0;
      w_state_next = SHIFT;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.out_valid  = (r_state == SHIFT);
  assign bus.out_data   = r_vec[DATA_BITS-1:0];
  assign bus.out_last   = w_last;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Beat counter and word storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the word storage is cleared on reset on purpose: out_data is
      // driven straight from it and must read 0 after reset.
      r_count <= '0;
      r_vec   <= '0;
    end else begin
      r_count <= w_count_next;
      r_vec   <= w_vec_next;
    end
  end

endmodule

// File: tb/tb_shift_unloader.sv
// Self-checking bench for shift_unloader (DATA_BITS=8/LENGTH=4 plus a
// DATA_BITS=16/LENGTH=1 instance). The main instance is compared every cycle
// against a queue of expected words; build with or without
// SHIFT_UNLOADER_BACKTOBACK_EN to match the RTL.
module tb_shift_unloader;

  localparam int DB = 8;
  localparam int L  = 4;
`ifdef SHIFT_UNLOADER_BACKTOBACK_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  typedef struct {
    logic [DB-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  beat_t q[$];          // words still owed by the main instance, in order
  logic  s_ov, s_beat, s_load;

  shift_unloader_if #(.DATA_BITS(DB), .LENGTH(L)) m_if ();
  shift_unloader_if #(.DATA_BITS(16), .LENGTH(1)) s_if ();

  shift_unloader #(.DATA_BITS(DB), .LENGTH(L)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (m_if)
  );

  shift_unloader #(.DATA_BITS(16), .LENGTH(1)) u_dut_l1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (s_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs at the falling edge, then apply the model's
  // view of both handshakes at the rising edge. Returns 1 ns after it.
  task automatic step();
    logic          ev, lr, bf, lf;
    logic [DB*L-1:0] vec;
    @(negedge clk);
    ev  = (q.size() != 0);
    lr  = rst_n && ((q.size() == 0) || (BTB_EN && q.size() == 1 && m_if.out_ready));
    check("load_ready", m_if.load_ready, lr);
    check("out_valid", m_if.out_valid, ev);
    if (ev) begin
      check("out_data", m_if.out_data, q[0].data);
      check("out_last", m_if.out_last, q[0].last);
    end
    bf     = ev && m_if.out_ready;
    lf     = m_if.load_valid && lr;
    vec    = m_if.load_data;
    s_ov   = m_if.out_valid;
    s_beat = bf;
    s_load = lf;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bf) void'(q.pop_front());
      if (lf)
        for (int i = 0; i < L; i++)
          q.push_back(beat_t'{data: vec[i*DB +: DB], last: (i == L-1)});
    end
    #1;
  endtask

  task automatic wait_load(input logic [31:0] v);
    bit done = 1'b0;
    m_if.load_valid = 1'b1;
    m_if.load_data  = v;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = s_load;
    end
    m_if.load_valid = 1'b0;
    if (!done) check("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(output int beats);
    beats = 0;
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      step();
      if (s_beat) beats++;
    end
    if (q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int  beats, gaps;
    bit  loaded_a, loaded_b;

    rst_n            = 1'b0;
    m_if.load_valid  = 1'b0;
    m_if.load_data   = '0;
    m_if.out_ready   = 1'b0;
    s_if.load_valid  = 1'b0;
    s_if.load_data   = '0;
    s_if.out_ready   = 1'b0;

    // Reset state
    step();
    step();
    check("reset_out_data", m_if.out_data, 32'h0);
    check("reset_out_last", m_if.out_last, 32'h0);
    check("reset_load_ready", m_if.load_ready, 32'h0);
    check("reset_l1_valid", s_if.out_valid, 32'h0);
    rst_n = 1'b1;
    step();

    // Basic unload at full consumer rate
    m_if.out_ready = 1'b1;
    wait_load(32'h4433_2211);
    drain(beats);
    check("basic_beats", beats, 32'd4);
    step();
    check("basic_idle", m_if.out_valid, 32'h0);

    // Backpressure on word 22
    wait_load(32'h4433_2211);
    step();                               // word 11 leaves
    m_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", m_if.out_data, 32'h22);
      check("bp_hold_last", m_if.out_last, 32'h0);
    end
    drain(beats);
    check("bp_rest_beats", beats, 32'd3);

    // Two vectors, second offered at the last beat of the first
    m_if.out_ready = 1'b1;
    loaded_a = 1'b0;
    loaded_b = 1'b0;
    beats    = 0;
    gaps     = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      if (!loaded_a) begin
        m_if.load_valid = 1'b1;
        m_if.load_data  = 32'h4433_2211;
      end else if (!loaded_b && q.size() <= 1) begin
        m_if.load_valid = 1'b1;
        m_if.load_data  = 32'hDDCC_BBAA;
      end else begin
        m_if.load_valid = 1'b0;
      end
      step();
      if (s_load) begin
        if (!loaded_a) loaded_a = 1'b1;
        else           loaded_b = 1'b1;
      end
      if (!s_ov && beats > 0 && beats < 8) gaps++;
      if (s_beat) beats++;
    end
    m_if.load_valid = 1'b0;
    check("b2b_beats", beats, 32'd8);
    check("b2b_gap", gaps, BTB_EN ? 32'd0 : 32'd1);

    // Reset in the middle of a vector
    wait_load(32'h4433_2211);
    step();
    step();                               // 11 and 22 delivered
    rst_n = 1'b0;
    step();
    check("rst_out_valid", m_if.out_valid, 32'h0);
    check("rst_out_data", m_if.out_data, 32'h0);
    check("rst_out_last", m_if.out_last, 32'h0);
    check("rst_load_ready", m_if.load_ready, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", m_if.load_ready, 32'h1);
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_beat) beats++;
    end
    check("rst_no_stale_beats", beats, 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      m_if.load_valid = ($urandom_range(0, 2) != 0);
      m_if.load_data  = $urandom;
      m_if.out_ready  = ($urandom_range(0, 3) != 0);
      rst_n           = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n           = 1'b1;
    m_if.load_valid = 1'b0;
    drain(beats);

    // LENGTH=1, DATA_BITS=16
    s_if.load_valid = 1'b1;
    s_if.load_data  = 16'hBEEF;
    s_if.out_ready  = 1'b1;
    #1;
    check("l1_load_ready", s_if.load_ready, 32'h1);
    step();
    s_if.load_valid = 1'b0;
    check("l1_valid", s_if.out_valid, 32'h1);
    check("l1_data", s_if.out_data, 32'h0000_BEEF);
    check("l1_last", s_if.out_last, 32'h1);
    step();
    check("l1_idle_valid", s_if.out_valid, 32'h0);
    check("l1_idle_ready", s_if.load_ready, 32'h1);

    // LENGTH=1 under backpressure
    s_if.load_valid = 1'b1;
    s_if.load_data  = 16'h1234;
    s_if.out_ready  = 1'b0;
    step();
    s_if.load_valid = 1'b0;
    step();
    check("l1_bp_valid", s_if.out_valid, 32'h1);
    check("l1_bp_data", s_if.out_data, 32'h0000_1234);
    check("l1_bp_last", s_if.out_last, 32'h1);
    s_if.out_ready = 1'b1;
    step();
    check("l1_bp_done", s_if.out_valid, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
